// File: rtl/wb_reg_bank.sv
// Wishbone classic slave with NREGS 32-bit control/status registers at BASE_ADDR.
// Supports byte-lane writes, self-clearing pulse registers, read-only status words, and ERR on bad accesses.
module wb_reg_bank #(
  parameter logic [31:0]      BASE_ADDR  = 32'hb000_0000,
  parameter int               NREGS      = 8,
  parameter logic [NREGS-1:0] PULSE_MASK = 8'b0000_1010,
  parameter logic [NREGS-1:0] RO_MASK    = 8'b1000_0000
) (
  input  logic                   p_clk,
  input  logic                   p_reset,
  input  logic [31:0]            p_wb_DAT_I,
  output logic [31:0]            p_wb_DAT_O,
  input  logic [31:0]            p_wb_ADR_I,
  output logic                   p_wb_ACK_O,
  output logic                   p_wb_ERR_O,
  output logic                   p_wb_RTY_O,
  input  logic                   p_wb_CYC_I,
  input  logic                   p_wb_STB_I,
  input  logic                   p_wb_WE_I,
  input  logic [3:0]             p_wb_SEL_I,
  input  logic                   p_wb_LOCK_I,
  output logic [32*NREGS-1:0]    regs_o,
  output logic [NREGS-1:0]       wr_stb_o,
  input  logic [32*NREGS-1:0]    status_i
);

  localparam int          IDXW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(4 * NREGS);

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              req_s;
  logic [32:0]       adr_ext_s;
  logic [31:0]       off_s;
  logic [IDXW-1:0]   idx_s;
  logic              hit_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic [31:0]       rd_data_s;
  logic [NREGS-1:0]  wr_en_s;
  logic [31:0]       regs_r [NREGS];
  logic              ack_r;
  logic              err_r;
  logic [31:0]       dat_r;
  logic [NREGS-1:0]  wr_stb_r;
  logic              unused_s;

  // The upper-bound compare runs in 33 bits so a bank ending at 2^32 does not wrap.
  assign adr_ext_s = {1'b0, p_wb_ADR_I};
  assign off_s     = p_wb_ADR_I - BASE_ADDR;
  assign idx_s     = off_s[IDXW+1:2];
  assign hit_s     = (adr_ext_s >= BASE_EXT) && (adr_ext_s < LIMIT_EXT) && (p_wb_ADR_I[1:0] == 2'b00);
  assign unused_s  = ^{p_wb_LOCK_I, off_s[31:IDXW+2], off_s[1:0]};

  // State register.
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and request qualification.
  always_comb begin
    state_nx_s = IDLE;
    req_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (p_wb_CYC_I && p_wb_STB_I) begin
          req_s      = 1'b1;
          state_nx_s = RESP;
        end else begin
          req_s      = 1'b0;
          state_nx_s = IDLE;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Access classification and read-data selection.
  always_comb begin
    wr_ok_s   = 1'b0;
    rd_ok_s   = 1'b0;
    rd_data_s = 32'h0000_0000;
    if (hit_s) begin
      if (p_wb_WE_I) begin
        wr_ok_s = ~RO_MASK[idx_s];
      end else begin
        rd_ok_s   = 1'b1;
        rd_data_s = RO_MASK[idx_s] ? status_i[{idx_s, 5'b00000} +: 32] : regs_r[idx_s];
      end
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // One-hot write enable for the addressed register.
  always_comb begin
    wr_en_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      if (req_s && wr_ok_s && (idx_s == IDXW'(i))) begin
        wr_en_s[i] = 1'b1;
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  // Register storage; pulse registers fall back to zero on every cycle they are not written.
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en_s[i]) begin
          for (int k = 0; k < 4; k++) begin
            if (p_wb_SEL_I[k]) begin
              regs_r[i][8*k +: 8] <= p_wb_DAT_I[8*k +: 8];
            end
          end
        end else if (PULSE_MASK[i]) begin
          regs_r[i] <= 32'h0000_0000;
        end
      end
    end
  end

  // Registered termination, read data and write strobes.
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      dat_r    <= 32'h0000_0000;
      wr_stb_r <= {NREGS{1'b0}};
    end else begin
      ack_r    <= req_s & (wr_ok_s | rd_ok_s);
      err_r    <= req_s & ~(wr_ok_s | rd_ok_s);
      wr_stb_r <= wr_en_s;
      if (req_s && rd_ok_s) begin
        dat_r <= rd_data_s;
      end else if (req_s && !wr_ok_s) begin
        dat_r <= 32'h0000_0000;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_o[32*g +: 32] = regs_r[g];
  end

  // A master that abandons the cycle sees no termination.
  assign p_wb_ACK_O = ack_r & p_wb_CYC_I;
  assign p_wb_ERR_O = err_r & p_wb_CYC_I;
  assign p_wb_RTY_O = 1'b0;
  assign p_wb_DAT_O = dat_r;
  assign wr_stb_o   = wr_stb_r;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Self-checking bench for wb_reg_bank: transaction-level model compared every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_wb_reg_bank;

  localparam logic [31:0] BASE = 32'hb000_0000;
  localparam int          N    = 8;
  localparam logic [N-1:0] PM  = 8'b0000_1010;
  localparam logic [N-1:0] RM  = 8'b1000_0000;

  logic            p_clk = 1'b0;
  logic            p_reset;
  logic [31:0]     wb_dat_i;
  logic [31:0]     wb_dat_o;
  logic [31:0]     wb_adr;
  logic            wb_ack;
  logic            wb_err;
  logic            wb_rty;
  logic            wb_cyc;
  logic            wb_stb;
  logic            wb_we;
  logic [3:0]      wb_sel;
  logic            wb_lock;
  logic [32*N-1:0] regs_o;
  logic [N-1:0]    wr_stb_o;
  logic [32*N-1:0] status_i;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  always #5 p_clk = ~p_clk;

  wb_reg_bank dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .p_wb_DAT_I(wb_dat_i), .p_wb_DAT_O(wb_dat_o), .p_wb_ADR_I(wb_adr),
    .p_wb_ACK_O(wb_ack), .p_wb_ERR_O(wb_err), .p_wb_RTY_O(wb_rty),
    .p_wb_CYC_I(wb_cyc), .p_wb_STB_I(wb_stb), .p_wb_WE_I(wb_we),
    .p_wb_SEL_I(wb_sel), .p_wb_LOCK_I(wb_lock),
    .regs_o(regs_o), .wr_stb_o(wr_stb_o), .status_i(status_i)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit f_hit(input logic [31:0] a);
    longint unsigned x;
    x = {32'h0, a};
    return (x >= 64'hb000_0000) && (x < 64'hb000_0000 + 64'(4 * N)) && (x % 64'd4 == 64'd0);
  endfunction

  function automatic int f_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  logic [31:0]     m_regs [N];
  int              m_pend;     // 0 none, 1 ack next cycle, 2 err next cycle
  logic [31:0]     m_dat;
  logic [N-1:0]    m_stb;
  logic [32*N-1:0] m_regs_flat;

  always @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      for (int i = 0; i < N; i++) m_regs[i] <= 32'h0;
      m_pend <= 0;
      m_dat  <= 32'h0;
      m_stb  <= '0;
    end else begin
      for (int i = 0; i < N; i++) if (PM[i]) m_regs[i] <= 32'h0;
      m_pend <= 0;
      m_stb  <= '0;
      if (m_pend == 0 && wb_cyc && wb_stb) begin
        if (f_hit(wb_adr) && wb_we && !RM[f_idx(wb_adr)]) begin
          m_regs[f_idx(wb_adr)] <= f_merge(m_regs[f_idx(wb_adr)], wb_dat_i, wb_sel);
          m_stb[f_idx(wb_adr)]  <= 1'b1;
          m_pend <= 1;
        end else if (f_hit(wb_adr) && !wb_we) begin
          m_dat  <= RM[f_idx(wb_adr)] ? status_i[32*f_idx(wb_adr) +: 32] : m_regs[f_idx(wb_adr)];
          m_pend <= 1;
        end else begin
          m_dat  <= 32'h0;
          m_pend <= 2;
        end
      end
    end
  end

  always_comb begin
    m_regs_flat = '0;
    for (int i = 0; i < N; i++) m_regs_flat[32*i +: 32] = m_regs[i];
  end

  // Per-cycle comparison against the model.
  always @(negedge p_clk) begin
    if (chk_en) begin
      check("ack",    wb_ack,   (m_pend == 1) && wb_cyc);
      check("err",    wb_err,   (m_pend == 2) && wb_cyc);
      check("rty",    wb_rty,   1'b0);
      check("dat_o",  wb_dat_o, m_dat);
      check("regs",   regs_o,   m_regs_flat);
      check("wr_stb", wr_stb_o, m_stb);
    end
  end

  // ---------------- stimulus ----------------
  // Starts on the next edge; returns just after the request edge (inside the response cycle).
  task automatic start(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    @(posedge p_clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = a; wb_dat_i = d; wb_we = w; wb_sel = s;
    @(posedge p_clk); #1;
    wb_stb = 1'b0;
  endtask

  task automatic finish_cyc;
    @(posedge p_clk); #1;
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  logic [31:0] err_addrs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 32'h0;
    wb_dat_i = 32'h0; wb_sel = 4'h0; wb_lock = 1'b0;
    status_i = '0;
    status_i[31:0]       = 32'hFFFF_0000;
    status_i[32*7 +: 32] = 32'h1234_5678;
    err_addrs[0] = 32'hb000_0020; err_addrs[1] = 32'hb000_0002; err_addrs[2] = 32'ha000_0000;

    #1 p_reset = 1'b1;
    repeat (2) @(posedge p_clk);
    #1 p_reset = 1'b0;
    chk_en = 1'b1;
    @(negedge p_clk);
    check("rst_regs",   regs_o,   256'h0);
    check("rst_dat",    wb_dat_o, 32'h0);
    check("rst_ack",    wb_ack,   1'b0);
    check("rst_wr_stb", wr_stb_o, 8'h00);

    start(BASE, 32'h0, 1'b0, 4'hF);
    @(negedge p_clk);
    check("rd0_ack", wb_ack, 1'b1);
    check("rd0_dat", wb_dat_o, 32'h0);
    finish_cyc;

    start(BASE, 32'hDEAD_BEEF, 1'b1, 4'b0101);
    @(negedge p_clk);
    check("wr0_ack",   wb_ack, 1'b1);
    check("wr0_stb",   wr_stb_o, 8'h01);
    check("wr0_word",  regs_o[31:0], 32'h00AD_00EF);
    finish_cyc;
    @(negedge p_clk);
    check("wr0_stb_off", wr_stb_o, 8'h00);

    start(BASE, 32'h0, 1'b0, 4'h0);
    @(negedge p_clk);
    check("rd0b_dat", wb_dat_o, 32'h00AD_00EF);
    finish_cyc;

    start(BASE + 32'h4, 32'h5, 1'b1, 4'hF);
    @(negedge p_clk);
    check("pulse_val", regs_o[63:32], 32'h5);
    check("pulse_stb", wr_stb_o, 8'h02);
    finish_cyc;
    @(negedge p_clk);
    check("pulse_clr", regs_o[63:32], 32'h0);
    start(BASE + 32'h4, 32'h0, 1'b0, 4'hF);
    @(negedge p_clk);
    check("pulse_rd", wb_dat_o, 32'h0);
    finish_cyc;

    // Back-to-back pulse writes with STB held through the response cycle.
    @(posedge p_clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE + 32'hC; wb_dat_i = 32'hA5; wb_sel = 4'hF;
    @(posedge p_clk); #1;
    wb_dat_i = 32'h5A;
    @(negedge p_clk);
    check("b2b_v1",  regs_o[127:96], 32'hA5);
    @(posedge p_clk); #1;
    @(negedge p_clk);
    check("b2b_gap", regs_o[127:96], 32'h0);
    check("b2b_gap_ack", wb_ack, 1'b0);
    @(posedge p_clk); #1;
    wb_stb = 1'b0;
    @(negedge p_clk);
    check("b2b_v2",  regs_o[127:96], 32'h5A);
    check("b2b_ack", wb_ack, 1'b1);
    finish_cyc;

    start(BASE + 32'h1C, 32'h0, 1'b0, 4'hF);
    @(negedge p_clk);
    check("ro_rd", wb_dat_o, 32'h1234_5678);
    finish_cyc;
    start(BASE + 32'h1C, 32'hFFFF_FFFF, 1'b1, 4'hF);
    @(negedge p_clk);
    check("ro_wr_err", wb_err, 1'b1);
    check("ro_wr_ack", wb_ack, 1'b0);
    check("ro_wr_stb", wr_stb_o, 8'h00);
    finish_cyc;

    for (int e = 0; e < 3; e++) begin
      start(BASE, 32'h0, 1'b0, 4'hF);
      finish_cyc;
      start(err_addrs[e], 32'h0, 1'b0, 4'hF);
      @(negedge p_clk);
      check("bad_err", wb_err, 1'b1);
      check("bad_dat", wb_dat_o, 32'h0);
      finish_cyc;
      start(err_addrs[e], 32'h1357_9BDF, 1'b1, 4'hF);
      @(negedge p_clk);
      check("bad_wr_err", wb_err, 1'b1);
      finish_cyc;
    end

    start(BASE + 32'h18, 32'h0BAD_F00D, 1'b1, 4'hF);
    finish_cyc;
    start(BASE + 32'h18, 32'hFFFF_FFFF, 1'b1, 4'h0);
    @(negedge p_clk);
    check("sel0_ack",  wb_ack, 1'b1);
    check("sel0_stb",  wr_stb_o, 8'h40);
    check("sel0_word", regs_o[223:192], 32'h0BAD_F00D);
    finish_cyc;
    start(BASE + 32'h18, 32'h7766_5544, 1'b1, 4'b1000);
    @(negedge p_clk);
    check("sel8_word", regs_o[223:192], 32'h77AD_F00D);
    finish_cyc;

    // Reset arriving in the response cycle of a write.
    start(BASE + 32'h8, 32'h1122_3344, 1'b1, 4'hF);
    #1;
    check("rstmid_ack_pre", wb_ack, 1'b1);
    check("rstmid_word_pre", regs_o[95:64], 32'h1122_3344);
    #1 p_reset = 1'b1;
    #1;
    check("rstmid_ack", wb_ack, 1'b0);
    check("rstmid_word", regs_o[95:64], 32'h0);
    @(posedge p_clk); #1;
    p_reset = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;

    // Cycle abandoned during the response: no ACK, write stays committed.
    start(BASE + 32'h10, 32'hCAFE_F00D, 1'b1, 4'hF);
    wb_cyc = 1'b0;
    @(negedge p_clk);
    check("drop_ack",  wb_ack, 1'b0);
    check("drop_word", regs_o[159:128], 32'hCAFE_F00D);
    start(BASE + 32'h10, 32'h0, 1'b0, 4'hF);
    @(negedge p_clk);
    check("drop_rd", wb_dat_o, 32'hCAFE_F00D);
    finish_cyc;

    repeat (3) @(posedge p_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
